// File: rtl/sat_cnt_pkg.sv
// rtl/sat_cnt_pkg.sv - shared constants and parameter check for the saturating counter bank
package sat_cnt_pkg;

    localparam int MODE_SAT  = 0;
    localparam int MODE_WRAP = 1;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic bit sat_cnt_params_ok(
        input int     width,
        input int     channels,
        input longint sat_max,
        input longint lag_offset,
        input int     mode
    );
        longint top_val;
        if (width < 1 || width > 31) begin
            return 1'b0;
        end
        top_val = (longint'(1) << width) - 1;
        return (channels >= 1) && (sat_max >= 1) && (sat_max <= top_val) &&
               (lag_offset >= 0) && (lag_offset <= top_val) &&
               (mode == MODE_SAT || mode == MODE_WRAP);
    endfunction

endpackage

// File: rtl/sat_cnt_bank_if.sv
// rtl/sat_cnt_bank_if.sv - control and status bundle of the counter bank
interface sat_cnt_bank_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 5
);
    logic [CHANNELS-1:0]       en;
    logic [CHANNELS-1:0]       dir;
    logic [CHANNELS-1:0]       clr;
    logic [CHANNELS-1:0]       load;
    logic [CHANNELS*WIDTH-1:0] load_val;
    logic [CHANNELS*WIDTH-1:0] cnt;
    logic [CHANNELS*WIDTH-1:0] lag;
    logic [CHANNELS-1:0]       at_max;
    logic [CHANNELS-1:0]       at_min;
    logic [CHANNELS-1:0]       ovf;

    modport master (
        output en, dir, clr, load, load_val,
        input  cnt, lag, at_max, at_min, ovf
    );

    modport slave (
        input  en, dir, clr, load, load_val,
        output cnt, lag, at_max, at_min, ovf
    );
endinterface

// File: rtl/sat_cnt_chan.sv
// rtl/sat_cnt_chan.sv - one counter channel: bounded counter, sticky overflow, lagged offset copy
module sat_cnt_chan
    import sat_cnt_pkg::*;
#(
    parameter int WIDTH      = 5,
    parameter int SAT_MAX    = 3,
    parameter int LAG_OFFSET = 1,
    parameter int MODE       = MODE_SAT
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] lag,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] SAT_W = WIDTH'(SAT_MAX);
    localparam logic [WIDTH-1:0] LAG_W = WIDTH'(LAG_OFFSET);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] lag_q;
    logic             ovf_q;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_q <= '0;
            lag_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            // The lag copy tracks the pre-edge count regardless of control inputs
            lag_q <= cnt_q - LAG_W;
            if (clr) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (load) begin
                if (load_val > SAT_W) begin
                    cnt_q <= SAT_W;
                    ovf_q <= 1'b1;
                end else begin
                    cnt_q <= load_val;
                end
            end else if (en) begin
                if (dir == DIR_UP) begin
                    if (cnt_q < SAT_W) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        ovf_q <= 1'b1;
                        if (MODE == MODE_WRAP) begin
                            cnt_q <= '0;
                        end
                    end
                end else begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        ovf_q <= 1'b1;
                        if (MODE == MODE_WRAP) begin
                            cnt_q <= SAT_W;
                        end
                    end
                end
            end
        end
    end

    assign cnt    = cnt_q;
    assign lag    = lag_q;
    assign ovf    = ovf_q;
    assign at_max = (cnt_q == SAT_W);
    assign at_min = (cnt_q == '0);

endmodule

// File: rtl/sat_cnt_bank.sv
// rtl/sat_cnt_bank.sv - bank of independent saturating/wrapping counters with lagged offset view
module sat_cnt_bank
    import sat_cnt_pkg::*;
#(
    parameter int WIDTH      = 5,
    parameter int CHANNELS   = 2,
    parameter int SAT_MAX    = 3,
    parameter int LAG_OFFSET = 1,
    parameter int MODE       = MODE_SAT
) (
    input  logic               clk,
    input  logic               rst_,
    sat_cnt_bank_if.slave      bus
);

    if (!sat_cnt_params_ok(WIDTH, CHANNELS, SAT_MAX, LAG_OFFSET, MODE)) begin : g_bad_params
        $error("sat_cnt_bank: illegal parameter combination");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        sat_cnt_chan #(
            .WIDTH      (WIDTH),
            .SAT_MAX    (SAT_MAX),
            .LAG_OFFSET (LAG_OFFSET),
            .MODE       (MODE)
        ) u_chan (
            .clk      (clk),
            .rst_     (rst_),
            .en       (bus.en[i]),
            .dir      (bus.dir[i]),
            .clr      (bus.clr[i]),
            .load     (bus.load[i]),
            .load_val (bus.load_val[i*WIDTH +: WIDTH]),
            .cnt      (bus.cnt[i*WIDTH +: WIDTH]),
            .lag      (bus.lag[i*WIDTH +: WIDTH]),
            .at_max   (bus.at_max[i]),
            .at_min   (bus.at_min[i]),
            .ovf      (bus.ovf[i])
        );
    end

endmodule

// File: tb/tb_sat_cnt_bank.sv
// tb/tb_sat_cnt_bank.sv - directed self-checking bench for sat_cnt_bank
module tb_sat_cnt_bank;
    import sat_cnt_pkg::*;

    logic clk;
    logic rst_;
    int   total;
    int   bad;

    sat_cnt_bank_if #(.CHANNELS(2), .WIDTH(5)) bus0 ();
    sat_cnt_bank_if #(.CHANNELS(2), .WIDTH(5)) bus1 ();
    sat_cnt_bank_if #(.CHANNELS(4), .WIDTH(5)) bus2 ();

    sat_cnt_bank #(.WIDTH(5), .CHANNELS(2), .SAT_MAX(3), .LAG_OFFSET(1), .MODE(MODE_SAT))
        u_dut_sat (.clk(clk), .rst_(rst_), .bus(bus0));
    sat_cnt_bank #(.WIDTH(5), .CHANNELS(2), .SAT_MAX(3), .LAG_OFFSET(1), .MODE(MODE_WRAP))
        u_dut_wrap (.clk(clk), .rst_(rst_), .bus(bus1));
    sat_cnt_bank #(.WIDTH(5), .CHANNELS(4), .SAT_MAX(3), .LAG_OFFSET(1), .MODE(MODE_SAT))
        u_dut_quad (.clk(clk), .rst_(rst_), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [4:0]  exp_cnt [5];
    logic [4:0]  exp_lag [5];
    logic        exp_ovf [5];
    logic        exp_amx [5];
    logic [19:0] quad_lag;

    initial begin
        total = 0;
        bad   = 0;
        exp_cnt = '{5'd1, 5'd2, 5'd3, 5'd3, 5'd3};
        exp_lag = '{5'd31, 5'd0, 5'd1, 5'd2, 5'd2};
        exp_ovf = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_amx = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        rst_ = 1'b0;
        bus0.en = '0; bus0.dir = '0; bus0.clr = '0; bus0.load = '0; bus0.load_val = '0;
        bus1.en = '0; bus1.dir = '0; bus1.clr = '0; bus1.load = '0; bus1.load_val = '0;
        bus2.en = '0; bus2.dir = '0; bus2.clr = '0; bus2.load = '0; bus2.load_val = '0;
        #2;
        chk("rst_cnt", 32'(bus0.cnt), 32'd0);
        chk("rst_lag", 32'(bus0.lag), 32'd0);
        chk("rst_ovf", 32'(bus0.ovf), 32'd0);
        chk("rst_at_min", 32'(bus0.at_min), 32'd3);
        chk("rst_at_max", 32'(bus0.at_max), 32'd0);

        // Saturating up-count on channel 0
        rst_ = 1'b1;
        bus0.en = 2'b01; bus0.dir = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("up_cnt%0d", i), 32'(bus0.cnt[4:0]), 32'(exp_cnt[i]));
            chk($sformatf("up_lag%0d", i), 32'(bus0.lag[4:0]), 32'(exp_lag[i]));
            chk($sformatf("up_ovf%0d", i), 32'(bus0.ovf[0]), 32'(exp_ovf[i]));
            chk($sformatf("up_amax%0d", i), 32'(bus0.at_max[0]), 32'(exp_amx[i]));
        end
        chk("ch1_idle", 32'(bus0.cnt[9:5]), 32'd0);
        bus0.en = '0;

        // Clear, then loads with and without clamping
        bus0.clr = 2'b01; step(); bus0.clr = '0;
        chk("clr_cnt", 32'(bus0.cnt[4:0]), 32'd0);
        chk("clr_ovf", 32'(bus0.ovf[0]), 32'd0);
        bus0.load = 2'b01; bus0.load_val = 10'd7; step();
        chk("ld7_cnt", 32'(bus0.cnt[4:0]), 32'd3);
        chk("ld7_ovf", 32'(bus0.ovf[0]), 32'd1);
        bus0.load_val = 10'd2; step();
        chk("ld2_cnt", 32'(bus0.cnt[4:0]), 32'd2);
        chk("ld2_ovf", 32'(bus0.ovf[0]), 32'd1);

        // clr beats load and en
        bus0.clr = 2'b01; bus0.en = 2'b01; bus0.dir = 2'b01; bus0.load_val = 10'd1; step();
        chk("prio_cnt", 32'(bus0.cnt[4:0]), 32'd0);
        chk("prio_ovf", 32'(bus0.ovf[0]), 32'd0);
        bus0.clr = '0; bus0.en = '0; step();
        chk("ld1_cnt", 32'(bus0.cnt[4:0]), 32'd1);
        chk("ld1_lag", 32'(bus0.lag[4:0]), 32'd31);
        bus0.load = '0;

        // Wrap mode on the second bank
        bus1.load = 2'b01; bus1.load_val = 10'd3; step(); bus1.load = '0;
        chk("wrap_ld", 32'(bus1.cnt[4:0]), 32'd3);
        chk("wrap_ld_ovf", 32'(bus1.ovf[0]), 32'd0);
        bus1.en = 2'b01; bus1.dir = 2'b01; step();
        chk("wrap_up_cnt", 32'(bus1.cnt[4:0]), 32'd0);
        chk("wrap_up_ovf", 32'(bus1.ovf[0]), 32'd1);
        bus1.en = '0; bus1.clr = 2'b01; step(); bus1.clr = '0;
        chk("wrap_clr_ovf", 32'(bus1.ovf[0]), 32'd0);
        bus1.en = 2'b01; bus1.dir = 2'b00; step();
        chk("wrap_dn_cnt", 32'(bus1.cnt[4:0]), 32'd3);
        chk("wrap_dn_ovf", 32'(bus1.ovf[0]), 32'd1);
        chk("wrap_dn_amax", 32'(bus1.at_max), 32'd1);
        step();
        chk("wrap_dn2_cnt", 32'(bus1.cnt[4:0]), 32'd2);
        bus1.en = '0;

        // Four-channel independence
        bus2.en = 4'b0110; bus2.dir = 4'b0010;
        step(); step();
        bus2.en = '0;
        chk("quad_cnt", 32'(bus2.cnt), 32'({5'd0, 5'd0, 5'd2, 5'd0}));
        chk("quad_ovf", 32'(bus2.ovf), 32'd4);
        chk("quad_amin", 32'(bus2.at_min), 32'b1101);
        quad_lag = {5'd31, 5'd31, 5'd0, 5'd31};
        chk("quad_lag", 32'(bus2.lag), 32'(quad_lag));

        // Asynchronous reset mid-cycle
        bus0.load = 2'b01; bus0.load_val = 10'd3; step();
        bus0.load = '0; bus0.en = 2'b01; bus0.dir = 2'b01; step();
        bus0.en = '0;
        chk("pre_rst_cnt", 32'(bus0.cnt[4:0]), 32'd3);
        chk("pre_rst_ovf", 32'(bus0.ovf[0]), 32'd1);
        #2;
        rst_ = 1'b0;
        #1;
        chk("arst_cnt", 32'(bus0.cnt), 32'd0);
        chk("arst_lag", 32'(bus0.lag), 32'd0);
        chk("arst_ovf", 32'(bus0.ovf), 32'd0);
        chk("arst_quad_ovf", 32'(bus2.ovf), 32'd0);
        #1;
        rst_ = 1'b1;
        step();
        chk("post_rst_lag", 32'(bus0.lag[4:0]), 32'd31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sat_cnt_bank.md
Name: sat_cnt_bank

Overview:
- Bank of CHANNELS independent counters, each WIDTH bits wide, with a programmable limit and a one-cycle-lagged offset copy.
- Each counter can saturate or wrap at its limit, count up or down, be cleared or loaded, and report sticky overflow.
- Used wherever the design needs bounded event/retry counters plus a delayed "count minus offset" view for downstream compare logic.
- Single clock domain; all state is cleared by the asynchronous reset.

Parameters:
- WIDTH, 5: counter and lag width in bits.
- CHANNELS, 2: number of independent counter channels.
- SAT_MAX, 3: upper limit. Legal range is 1 <= SAT_MAX <= 2^WIDTH-1; elaboration fails outside it.
- LAG_OFFSET, 1: constant subtracted in the lag path. Legal range is 0 <= LAG_OFFSET < 2^WIDTH.
- MODE, 0: 0 = saturate at the limits, 1 = wrap between 0 and SAT_MAX.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_  input  1  asynchronous active-low reset.
- en  input  CHANNELS  per-channel count enable.
- dir  input  CHANNELS  per-channel direction: 1 = up, 0 = down.
- clr  input  CHANNELS  per-channel synchronous clear.
- load  input  CHANNELS  per-channel synchronous load strobe.
- load_val  input  CHANNELS*WIDTH  load data; channel i occupies bits [i*WIDTH +: WIDTH].
- cnt  output  CHANNELS*WIDTH  current counts, same packing as load_val.
- lag  output  CHANNELS*WIDTH  per channel, the count value from the previous clock edge minus LAG_OFFSET, modulo 2^WIDTH.
- at_max  output  CHANNELS  high when cnt == SAT_MAX.
- at_min  output  CHANNELS  high when cnt == 0.
- ovf  output  CHANNELS  sticky over/underflow flag.

Behaviour:
- Clock and reset: one clock, clk; reset rst_ is asynchronous, active-low.
- Reset values: cnt = 0, lag = 0, ovf = 0, so at_min = 1 and at_max = 0. Reset takes effect immediately, mid-operation, with no clock edge required.
- at_max and at_min are combinational decodes of the cnt registers. cnt, lag and ovf are registered.
- Per-channel priority at each rising clk edge: clr, then load, then en. Lower-priority inputs are ignored in a cycle where a higher-priority one is asserted.
- clr: cnt <= 0 and ovf <= 0.
- load:
  - cnt <= min(load_val, SAT_MAX); values above SAT_MAX are clamped.
  - If load_val > SAT_MAX, ovf <= 1; otherwise ovf holds.
- en with dir = 1, MODE 0: if cnt < SAT_MAX, cnt <= cnt + 1; else cnt holds and ovf <= 1.
- en with dir = 0, MODE 0: if cnt > 0, cnt <= cnt - 1; else cnt holds and ovf <= 1.
- en with MODE 1:
  - Up from SAT_MAX goes to 0, and ovf <= 1.
  - Down from 0 goes to SAT_MAX, and ovf <= 1.
  - Otherwise count by ±1.
- No enable: cnt and ovf hold.
- lag path:
  - Updates every cycle, independent of en, clr and load.
  - lag <= cnt_q - LAG_OFFSET, where cnt_q is the cnt value before the edge.
  - WIDTH-bit wrapping subtraction; no saturation.
  - Lag latency is one cycle behind cnt. Example: after reset with WIDTH = 5 and LAG_OFFSET = 1, the first edge gives lag = 31.
- Arithmetic: increment, decrement and compares use WIDTH bits, with compares unsigned. The counter path never produces a value above SAT_MAX.
- Channels are fully independent; simultaneous activity on all channels is legal.
- ovf is sticky. Only clr or reset clear it.

Decomposition:
- Package sat_cnt_pkg holds:
  - MODE_SAT = 0 and MODE_WRAP = 1 constants.
  - Direction constants DIR_UP = 1 and DIR_DN = 0.
  - A parameter-legality check function.
- Sub-module sat_cnt_chan implements one channel (counter, lag, ovf, flags). sat_cnt_bank instantiates it CHANNELS times in a generate loop and handles vector packing.

Test Plan:
- Reset, then en = 1 and dir = 1 on channel 0 for 5 clocks (WIDTH 5, SAT_MAX 3, MODE 0): cnt0 = 1, 2, 3, 3, 3; lag0 = 31, 0, 1, 2, 2; ovf0 rises on the 4th edge; at_max0 = 1 from the 3rd edge.
- MODE 1, SAT_MAX 3, count up from 3 → cnt = 0 and ovf = 1. Count down from 0 → cnt = 3.
- load_val = 7 with SAT_MAX 3 → cnt = 3, ovf = 1. load_val = 2 → cnt = 2, ovf unchanged.
- clr, load and en asserted together with cnt = 2 → cnt = 0, ovf = 0. Then load alone with 1 → cnt = 1.
- rst_ driven low between clock edges while cnt = 3 and ovf = 1 → cnt, lag and ovf are 0 immediately, before the next edge.
- CHANNELS 4: channel 1 counts up, channel 2 counts down from 0 (MODE 0), channel 3 idles → each behaves independently; only channel 2's ovf is set.
